// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: 2-flop synchronised rx, mid-bit sampling, one-cycle data_valid/frame_err pulses.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_module #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT_HI = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY  = 3'd5
`endif
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_out_n;
    logic                 data_valid_n;
    logic                 frame_err_n;
    logic                 sync1, rx_s;
    logic                 cnt_last, cnt_half, bit_last;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_n;
    logic                 parity_err_n;
`endif

    assign cnt_last = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign cnt_half = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign bit_last = (bit_idx == IDX_W'(DATA_BITS - 1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1      <= rx;
            rx_s       <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
            busy       <= (state_n != S_IDLE);
`ifdef UART_RX_PARITY_EN
            par_bit    <= par_bit_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n      = state;
        cnt_n        = cnt_last ? '0 : cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        data_out_n   = data_out;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
        parity_err_n = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt_half) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_last) begin
                        bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n   = S_PARITY;
`else
                        state_n   = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    par_bit_n = rx_s;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Returning to IDLE at stop mid-bit lets a back-to-back start edge be caught
                if (cnt_last) begin
                    if (rx_s) begin
                        data_out_n   = shreg;
                        data_valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_n = ^{shreg, par_bit};
`endif
                        state_n      = S_IDLE;
                    end else begin
                        frame_err_n  = 1'b1;
                        state_n      = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
